// File: rtl/vizinho_proximo_seq_pkg.sv
// Shared encodings for the nearest-neighbour scaler: scale mode, scale factor
// and the controller states.
package vizinho_proximo_seq_pkg;

  localparam logic MODO_AMPLIAR = 1'b0;
  localparam logic MODO_REDUZIR = 1'b1;

  localparam logic [1:0] FATOR_1X = 2'b00;
  localparam logic [1:0] FATOR_2X = 2'b01;
  localparam logic [1:0] FATOR_4X = 2'b10;
  localparam logic [1:0] FATOR_8X = 2'b11;

  typedef enum logic [2:0] {
    OCIOSO,
    LER,
    ESPERA,
    ESCREVE,
    FIM
  } estado_t;

endpackage

// File: rtl/vizinho_proximo_seq_gerador_coordenadas.sv
// Raster walker for the destination image: keeps xd/yd plus the destination and
// source row bases, and derives the current and next source/destination addresses.
module gerador_coordenadas
  import vizinho_proximo_seq_pkg::*;
#(
  parameter int LARGURA_ORIG = 160,
  parameter int ADDR_ORIG_W  = 15,
  parameter int ADDR_DEST_W  = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   limpa,
  input  logic                   avanca,
  input  logic                   modo,
  input  logic [1:0]             k,
  input  logic [ADDR_DEST_W-1:0] largura,
  input  logic [ADDR_DEST_W-1:0] altura,
  output logic [ADDR_ORIG_W-1:0] src_addr,
  output logic [ADDR_ORIG_W-1:0] prox_src_addr,
  output logic [ADDR_DEST_W-1:0] dest_addr,
  output logic                   fim_linha,
  output logic                   ultimo
);

  logic [ADDR_DEST_W-1:0] xd_q, xd_d, xd_n;
  logic [ADDR_DEST_W-1:0] yd_q, yd_d, yd_n;
  logic [ADDR_DEST_W-1:0] dest_base_q, dest_base_d, dest_base_n;
  logic [ADDR_ORIG_W-1:0] src_base_q, src_base_d, src_base_n;
  logic [ADDR_DEST_W-1:0] mascara;

  function automatic logic [ADDR_ORIG_W-1:0] coluna(input logic [ADDR_DEST_W-1:0] x,
                                                    input logic m, input logic [1:0] kk);
    logic [ADDR_DEST_W-1:0] c;
    c = (m == MODO_REDUZIR) ? (x << kk) : (x >> kk);
    return ADDR_ORIG_W'(c);
  endfunction

  // In zoom-in the source row only moves after 2^k destination rows.
  always_comb begin
    fim_linha   = (xd_q == largura - ADDR_DEST_W'(1));
    ultimo      = fim_linha && (yd_q == altura - ADDR_DEST_W'(1));
    mascara     = (ADDR_DEST_W'(1) << k) - ADDR_DEST_W'(1);
    xd_n        = xd_q + ADDR_DEST_W'(1);
    yd_n        = yd_q;
    dest_base_n = dest_base_q;
    src_base_n  = src_base_q;
    if (fim_linha) begin
      xd_n        = '0;
      yd_n        = yd_q + ADDR_DEST_W'(1);
      dest_base_n = dest_base_q + largura;
      if (modo == MODO_REDUZIR) begin
        src_base_n = src_base_q + (ADDR_ORIG_W'(LARGURA_ORIG) << k);
      end else if ((yd_q & mascara) == mascara) begin
        src_base_n = src_base_q + ADDR_ORIG_W'(LARGURA_ORIG);
      end
    end

    xd_d        = xd_q;
    yd_d        = yd_q;
    dest_base_d = dest_base_q;
    src_base_d  = src_base_q;
    if (limpa) begin
      xd_d        = '0;
      yd_d        = '0;
      dest_base_d = '0;
      src_base_d  = '0;
    end else if (avanca) begin
      xd_d        = xd_n;
      yd_d        = yd_n;
      dest_base_d = dest_base_n;
      src_base_d  = src_base_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xd_q        <= '0;
      yd_q        <= '0;
      dest_base_q <= '0;
      src_base_q  <= '0;
    end else begin
      xd_q        <= xd_d;
      yd_q        <= yd_d;
      dest_base_q <= dest_base_d;
      src_base_q  <= src_base_d;
    end
  end

  assign src_addr      = src_base_q + coluna(xd_q, modo, k);
  assign prox_src_addr = src_base_n + coluna(xd_n, modo, k);
  assign dest_addr     = dest_base_q + xd_q;

endmodule

// File: rtl/vizinho_proximo_seq.sv
// Sequential nearest-neighbour scaler: reads one source pixel per distinct source
// address and writes every destination pixel in raster order.
module vizinho_proximo_seq
  import vizinho_proximo_seq_pkg::*;
#(
  parameter int LARGURA_ORIG = 160,
  parameter int ALTURA_ORIG  = 120,
  parameter int PIXEL_W      = 8,
  parameter int ADDR_ORIG_W  = 15,
  parameter int ADDR_DEST_W  = 19,
  parameter int RD_LAT       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   modo,
  input  logic [1:0]             fator,
  output logic                   rd_en,
  output logic [ADDR_ORIG_W-1:0] rd_addr,
  input  logic [PIXEL_W-1:0]     rd_data,
  output logic                   wr_en,
  output logic [ADDR_DEST_W-1:0] wr_addr,
  output logic [PIXEL_W-1:0]     wr_data,
  input  logic                   wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   erro
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  estado_t                estado_q, estado_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   modo_q, modo_d;
  logic [1:0]             k_q, k_d;
  logic [ADDR_ORIG_W-1:0] tag_q, tag_d;
  logic                   valido_q, valido_d;
  logic [PIXEL_W-1:0]     pixel_q, pixel_d;
  logic                   erro_q, erro_d;

  logic                   limpa, avanca, rejeita, vazio;
  logic [ADDR_DEST_W-1:0] largura, altura, dest_addr;
  logic [ADDR_ORIG_W-1:0] src_addr, prox_src_addr;
  logic                   fim_linha, ultimo;

  function automatic logic [ADDR_DEST_W-1:0] escala(input int base, input logic m,
                                                    input logic [1:0] kk);
    logic [ADDR_DEST_W-1:0] b;
    b = ADDR_DEST_W'(base);
    return (m == MODO_REDUZIR) ? (b >> kk) : (b << kk);
  endfunction

  assign largura = escala(LARGURA_ORIG, modo_q, k_q);
  assign altura  = escala(ALTURA_ORIG, modo_q, k_q);
  assign rejeita = (modo == MODO_AMPLIAR) && (fator == FATOR_8X);
  // A zoom-out that floors to an empty image finishes without touching memory.
  assign vazio   = (escala(LARGURA_ORIG, modo, fator) == '0) ||
                   (escala(ALTURA_ORIG, modo, fator) == '0);

  gerador_coordenadas #(
    .LARGURA_ORIG(LARGURA_ORIG),
    .ADDR_ORIG_W (ADDR_ORIG_W),
    .ADDR_DEST_W (ADDR_DEST_W)
  ) u_gerador (
    .clk          (clk),
    .rst          (rst),
    .limpa        (limpa),
    .avanca       (avanca),
    .modo         (modo_q),
    .k            (k_q),
    .largura      (largura),
    .altura       (altura),
    .src_addr     (src_addr),
    .prox_src_addr(prox_src_addr),
    .dest_addr    (dest_addr),
    .fim_linha    (fim_linha),
    .ultimo       (ultimo)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    modo_d   = modo_q;
    k_d      = k_q;
    tag_d    = tag_q;
    valido_d = valido_q;
    pixel_d  = pixel_q;
    erro_d   = 1'b0;
    limpa    = 1'b0;
    avanca   = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (start) begin
          if (rejeita) begin
            erro_d = 1'b1;
          end else begin
            modo_d   = modo;
            k_d      = fator;
            valido_d = 1'b0;
            limpa    = 1'b1;
            estado_d = vazio ? FIM : LER;
          end
        end
      end
      LER: begin
        rd_en    = 1'b1;
        cnt_d    = '0;
        tag_d    = src_addr;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          pixel_d  = rd_data;
          valido_d = 1'b1;
          estado_d = ESCREVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ESCREVE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          if (ultimo) begin
            estado_d = FIM;
          end else begin
            avanca = 1'b1;
            // A row change always re-reads, even if the address would match.
            if (valido_q && !fim_linha && (prox_src_addr == tag_q)) begin
              estado_d = ESCREVE;
            end else begin
              estado_d = LER;
            end
          end
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      modo_q   <= MODO_AMPLIAR;
      k_q      <= FATOR_1X;
      tag_q    <= '0;
      valido_q <= 1'b0;
      pixel_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      modo_q   <= modo_d;
      k_q      <= k_d;
      tag_q    <= tag_d;
      valido_q <= valido_d;
      pixel_q  <= pixel_d;
      erro_q   <= erro_d;
    end
  end

  assign rd_addr = src_addr;
  assign wr_addr = dest_addr;
  assign wr_data = pixel_q;
  assign busy    = (estado_q != OCIOSO);
  assign done    = (estado_q == FIM);
  assign erro    = erro_q;

endmodule

// File: tb/tb_vizinho_proximo_seq.sv
// Scoreboard bench for vizinho_proximo_seq on a 4x4 source image with a
// two-cycle source memory model.
module tb_vizinho_proximo_seq;
  import vizinho_proximo_seq_pkg::*;

  localparam int L  = 4;
  localparam int A  = 4;
  localparam int PW = 8;
  localparam int SW = 15;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst, start, modo, wr_ready;
  logic [1:0]    fator;
  logic          rd_en, wr_en, busy, done, erro;
  logic [SW-1:0] rd_addr;
  logic [PW-1:0] rd_data;
  logic [DW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [PW-1:0] data;
  } wr_exp_t;

  wr_exp_t       wr_q[$];
  logic [SW-1:0] rd_q[$];
  int tests = 0, fails = 0;
  int n_reads = 0, n_writes = 0, n_done = 0;
  logic          a1_v = 1'b0;
  logic [SW-1:0] a1 = '0;

  vizinho_proximo_seq #(
    .LARGURA_ORIG(L), .ALTURA_ORIG(A), .PIXEL_W(PW),
    .ADDR_ORIG_W(SW), .ADDR_DEST_W(DW), .RD_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .modo(modo), .fator(fator),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pix(input logic [SW-1:0] a);
    return PW'(a * 7 + 49);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Source memory: data shows up two cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    a1_v    <= rd_en;
    a1      <= rd_addr;
    rd_data <= a1_v ? pix(a1) : 8'hEE;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        n_reads++;
        checkOutput("rd_expected", 64'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) checkOutput("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
      end
      if (wr_en && wr_ready) begin
        n_writes++;
        checkOutput("wr_expected", 64'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) checkOutput("wr_addr_data", 64'({wr_addr, wr_data}),
                                         64'(wr_q.pop_front()));
      end
      if (done) begin
        n_done++;
        checkOutput("done_queue_empty", 64'(wr_q.size()), 0);
      end
    end
  end

  task automatic expect_pixel(input int dest, input int src);
    wr_q.push_back({DW'(dest), pix(SW'(src))});
  endtask

  task automatic expect_copy();
    for (int i = 0; i < L * A; i++) begin
      rd_q.push_back(SW'(i));
      expect_pixel(i, i);
    end
  endtask

  task automatic expect_zoom_in2();
    for (int yd = 0; yd < 2 * A; yd++)
      for (int xd = 0; xd < 2 * L; xd++) begin
        if (xd % 2 == 0) rd_q.push_back(SW'((yd / 2) * L + xd / 2));
        expect_pixel(yd * 2 * L + xd, (yd / 2) * L + xd / 2);
      end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] f);
    @(posedge clk); #1;
    modo = m; fator = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; modo = ~m; fator = ~f;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("done_seen", 64'(done), 1);
  endtask

  task automatic frame_end(input string tag, input int r0, input int w0, input int d0,
                           input int er, input int ew);
    @(posedge clk); #1;
    checkOutput({tag, "_busy_low"}, 64'({busy, done}), 0);
    checkOutput({tag, "_reads"}, 64'(n_reads - r0), 64'(er));
    checkOutput({tag, "_writes"}, 64'(n_writes - w0), 64'(ew));
    checkOutput({tag, "_done_count"}, 64'(n_done - d0), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, r0, w0, d0, g;
    logic [DW-1:0] held_a;
    logic [PW-1:0] held_d;
    rst = 1'b1; start = 1'b0; modo = 1'b0; fator = 2'b00; wr_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_outputs",
                64'({rd_en, wr_en, busy, done, erro, rd_addr, wr_addr, wr_data}), 0);
    rst = 1'b0;

    $display("[TB] zoom-out 2x");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    rd_q.push_back(0); rd_q.push_back(2); rd_q.push_back(8); rd_q.push_back(10);
    expect_pixel(0, 0); expect_pixel(1, 2); expect_pixel(2, 8); expect_pixel(3, 10);
    applyStimulus(MODO_REDUZIR, FATOR_2X);
    checkOutput("out2_busy", 64'(busy), 1);
    waitDone(cyc);
    checkOutput("out2_cycles", 64'(cyc), 16);
    frame_end("out2", r0, w0, d0, 4, 4);

    $display("[TB] zoom-in 2x");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    expect_zoom_in2();
    applyStimulus(MODO_AMPLIAR, FATOR_2X);
    waitDone(cyc);
    checkOutput("in2_cycles", 64'(cyc), 160);
    frame_end("in2", r0, w0, d0, 32, 64);

    $display("[TB] copy, zoom-in mode");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    expect_copy();
    applyStimulus(MODO_AMPLIAR, FATOR_1X);
    waitDone(cyc);
    checkOutput("copy0_cycles", 64'(cyc), 64);
    frame_end("copy0", r0, w0, d0, 16, 16);

    $display("[TB] copy, zoom-out mode, with write stall");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    expect_copy();
    wr_ready = 1'b0;
    applyStimulus(MODO_REDUZIR, FATOR_1X);
    g = 0;
    while (!wr_en && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("stall_wr_en_seen", 64'(wr_en), 1);
    held_a = wr_addr; held_d = wr_data;
    checkOutput("stall_first_pixel", 64'({held_a, held_d}), 64'({DW'(0), pix(0)}));
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("stall_wr_en", 64'(wr_en), 1);
      checkOutput("stall_hold", 64'({wr_addr, wr_data}), 64'({held_a, held_d}));
      checkOutput("stall_no_read", 64'(rd_en), 0);
    end
    wr_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_resume", 64'({wr_en, rd_en}), 64'(2'b01));
    waitDone(cyc);
    frame_end("copy1", r0, w0, d0, 16, 16);

    $display("[TB] rejected start");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    applyStimulus(MODO_AMPLIAR, FATOR_8X);
    checkOutput("rej_erro", 64'({erro, busy}), 64'(2'b10));
    @(posedge clk); #1;
    checkOutput("rej_erro_pulse", 64'(erro), 0);
    repeat (10) @(posedge clk); #1;
    checkOutput("rej_idle", 64'({busy, n_reads - r0, n_writes - w0, n_done - d0}), 0);

    $display("[TB] start while busy");
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    expect_copy();
    applyStimulus(MODO_REDUZIR, FATOR_1X);
    repeat (10) @(posedge clk); #1;
    applyStimulus(MODO_AMPLIAR, FATOR_2X);
    waitDone(cyc);
    frame_end("busy_start", r0, w0, d0, 16, 16);
    repeat (20) @(posedge clk); #1;
    checkOutput("busy_start_no_extra", 64'({busy, 32'(n_done - d0)}), 1);

    $display("[TB] reset mid-frame");
    w0 = n_writes;
    expect_copy();
    applyStimulus(MODO_REDUZIR, FATOR_1X);
    g = 0;
    while (n_writes - w0 < 5 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("rst_after_5_writes", 64'(n_writes - w0), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_midframe_outputs",
                64'({rd_en, wr_en, busy, done, erro, rd_addr, wr_addr, wr_data}), 0);
    rst = 1'b0;
    wr_q.delete(); rd_q.delete();
    r0 = n_reads; w0 = n_writes; d0 = n_done;
    expect_copy();
    applyStimulus(MODO_AMPLIAR, FATOR_1X);
    waitDone(cyc);
    checkOutput("post_rst_cycles", 64'(cyc), 64);
    frame_end("post_rst", r0, w0, d0, 16, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
